// File: rtl/fnd_display_scheduler.sv
// Round-robin time-multiplexer that shares one 4-digit FND between four value sources.
// Define FND_SCHED_SAT_EN to clamp every displayed value to 9999.
module fnd_display_scheduler #(
    parameter int DWELL_CYCLES = 100_000_000,
    parameter int CNT_W        = 27
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_enable,
    input  logic        i_hold,
    input  logic [3:0]  i_valid,
    input  logic [55:0] i_values,
    output logic [13:0] o_value,
    output logic [1:0]  o_src,
    output logic        o_onoff,
    output logic        o_switch
);

    typedef enum logic [1:0] {
        IDLE,
        NEXT,
        SHOW
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DWELL_CYCLES - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] dwell_cnt;
    logic [CNT_W-1:0] dwell_cnt_nxt;
    logic [13:0]      value_nxt;
    logic [1:0]       src_nxt;
    logic             onoff_nxt;
    logic             switch_nxt;
    logic [13:0]      src_val [4];
    logic             found;
    logic [1:0]       pick;

    function automatic logic [13:0] shape(input logic [13:0] v);
`ifdef FND_SCHED_SAT_EN
        return (v > 14'd9999) ? 14'd9999 : v;
`else
        return v;
`endif
    endfunction

    always_comb begin
        for (int n = 0; n < 4; n++) begin
            src_val[n] = i_values[14*n +: 14];
        end
    end

    // Search starts one past the current source and ends on the current source itself.
    always_comb begin
        found = 1'b0;
        pick  = o_src;
        for (int k = 1; k <= 4; k++) begin
            if (!found && i_valid[o_src + 2'(k)]) begin
                found = 1'b1;
                pick  = o_src + 2'(k);
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        dwell_cnt_nxt = dwell_cnt;
        value_nxt     = o_value;
        src_nxt       = o_src;
        onoff_nxt     = o_onoff;
        switch_nxt    = 1'b0;
        unique case (state)
            IDLE: begin
                onoff_nxt = 1'b0;
                if (i_enable && (i_valid != 4'b0000)) begin
                    state_nxt = NEXT;
                end
            end
            NEXT: begin
                if (i_enable && found) begin
                    state_nxt     = SHOW;
                    src_nxt       = pick;
                    value_nxt     = shape(src_val[pick]);
                    dwell_cnt_nxt = '0;
                    onoff_nxt     = 1'b1;
                    switch_nxt    = (pick != o_src);
                end else begin
                    state_nxt = IDLE;
                    onoff_nxt = 1'b0;
                end
            end
            SHOW: begin
                value_nxt = shape(src_val[o_src]);
                if (!i_hold) begin
                    dwell_cnt_nxt = dwell_cnt + 1'b1;
                end
                if (!i_enable) begin
                    state_nxt = IDLE;
                end else if (!i_valid[o_src]) begin
                    state_nxt = NEXT;
                end else if (!i_hold && (dwell_cnt == LAST_CNT)) begin
                    state_nxt = NEXT;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state     <= IDLE;
            dwell_cnt <= '0;
            o_value   <= '0;
            o_src     <= '0;
            o_onoff   <= 1'b0;
            o_switch  <= 1'b0;
        end else begin
            state     <= state_nxt;
            dwell_cnt <= dwell_cnt_nxt;
            o_value   <= value_nxt;
            o_src     <= src_nxt;
            o_onoff   <= onoff_nxt;
            o_switch  <= switch_nxt;
        end
    end

endmodule

// File: doc/fnd_display_scheduler.md
# fnd_display_scheduler

Time-multiplexes one 4-digit FND display between four independent value sources. Rotates round-robin among the sources that currently hold valid data, showing each for a programmable dwell time, and drives the FND controller's 14-bit value input and on/off enable. Sits directly upstream of the FND controller, in the same `i_clk` domain.

## Interface

- `DWELL_CYCLES`, default 100_000_000: clock cycles each source is shown (1 s at 100 MHz); must be ≥ 2.
- `CNT_W`, default 27: dwell counter width; must satisfy 2^CNT_W ≥ DWELL_CYCLES.

- `i_clk` in 1: system clock, rising edge.
- `i_reset` in 1: asynchronous, active-low reset.
- `i_enable` in 1: scheduler enable; low forces IDLE.
- `i_hold` in 1: freezes the dwell counter, so the current source stays on display.
- `i_valid` in 4: per-source data-valid level, bit n = source n.
- `i_values` in 56: packed source values, source n in bits [14n+13:14n].
- `o_value` out 14: value to the FND controller.
- `o_src` out 2: index of the source currently displayed.
- `o_onoff` out 1: display enable to the FND controller; 1 = display on.
- `o_switch` out 1: one-cycle pulse when `o_src` changes.

## Operation

- States: IDLE, NEXT, SHOW. State, `o_value`, `o_src`, `o_onoff`, `o_switch` and the dwell counter are all registered.
- Reset, while `i_reset`=0: state IDLE, `o_value`=0, `o_src`=0, `o_onoff`=0, `o_switch`=0, dwell counter 0.
- **IDLE**
  - `o_onoff`=0; `o_value` and `o_src` hold.
  - `i_enable`=1 and `i_valid`≠0 → NEXT.
- **NEXT** (exactly one cycle)
  - Search order: `o_src`+1, +2, +3, then `o_src` itself, all mod 4. The first source with its valid bit set is chosen.
  - On the exit edge: `o_src` ← chosen source; `o_value` ← that source's value; dwell counter ← 0; `o_onoff` ← 1.
  - `o_switch` ← 1 only if the chosen index differs from the old `o_src`.
  - Then → SHOW.
  - No valid source, or `i_enable`=0 → IDLE, with `o_onoff` ← 0.
  - `o_onoff` keeps its prior value while in NEXT, so a SHOW→NEXT→SHOW transition causes no display blink.
- **SHOW**
  - `o_value` ← value of `o_src` every cycle, so it tracks live data with a 1-cycle lag.
  - The dwell counter increments each cycle unless `i_hold`=1.
  - Exit conditions, in priority order:
    1. `i_enable`=0 → IDLE.
    2. `i_valid[o_src]`=0 → NEXT.
    3. Counter = DWELL_CYCLES−1 with `i_hold`=0 → NEXT.
- `o_switch` is 0 in every cycle except the one following a NEXT→SHOW edge that changed the source.
- Single valid source: NEXT reselects the same source, the dwell restarts, and `o_switch` stays 0.
- A source that becomes valid mid-dwell waits for the next NEXT; it does not preempt.
- Reset mid-operation takes effect immediately, asynchronously, to the reset values. The first NEXT after reset starts its search at source 1.

## Timing

- With `i_valid` sampled at edge k in IDLE: NEXT follows edge k. At edge k+1, `o_src`, `o_value`, `o_onoff`=1 and `o_switch` update together.
- Without hold, each rotation period per source is DWELL_CYCLES cycles in SHOW plus 1 cycle in NEXT.
- Value tracking in SHOW: a change on the selected slice at edge j appears on `o_value` after edge j+1.
- Loss of valid on the displayed source at edge j: NEXT after edge j; new `o_src`/`o_value` after edge j+1.
- `i_enable` falling at edge j: `o_onoff`=0 after edge j+1.

## Configuration

- `FND_SCHED_SAT_EN` defined: every value loaded into `o_value` is clamped, so inputs > 9999 give 9999, and values ≤ 9999 pass unchanged.
- `FND_SCHED_SAT_EN` undefined: raw 14-bit value passes through unchanged (0–16383).

## Test plan

Bench parameters: `DWELL_CYCLES`=8; both builds.

- Reset, enable=1, valid=4'b0001, source0=1234 → `o_src`=0, `o_value`=1234, `o_onoff`=1 two cycles after valid. `o_switch` stays 0 because `o_src` was already 0.
- Valid=4'b1011 with values 11/22/—/44 → display order 0→1→3→0, each held 8 SHOW cycles plus 1 NEXT cycle. `o_switch` pulses once per change; `o_onoff` never drops.
- While showing source 1, drop `i_valid[1]` → next valid source shown two edges later; the dwell counter restarts.
- `i_hold`=1 for 20 cycles during SHOW → `o_src` is unchanged throughout. Rotation resumes with the remaining dwell after hold releases.
- Source value 12000:
  - with `FND_SCHED_SAT_EN` → `o_value`=9999;
  - without → `o_value`=12000.
  - The same value change mid-SHOW appears one cycle later in both builds.
- `i_enable`=0 mid-SHOW → `o_onoff`=0 and IDLE. Asserting `i_reset`=0 during SHOW → all outputs go to their reset values asynchronously; after release with valid=4'b1111, the first source shown is 1.
